instr_mem_ctrl: RTL and testbench

- Upstream responder for the fetch unit's instruction bus.
- Accepts a fetch read request on the `re`/`sel`/`addr` bus and services it from a synchronous-read instruction SRAM, with configurable wait states and SRAM read latency.
- Returns `ack` plus the 32-bit `instr` word.
- Handles abandoned requests (fetch redirect drops `re`) and bad addresses (misaligned or outside the mapped window).

---
 rtl/instr_mem_ctrl_pkg.sv | 23 ++
 rtl/instr_mem_ctrl_lat_counter.sv | 24 ++
 rtl/instr_mem_ctrl.sv | 114 +++++++++++
 tb/tb_instr_mem_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared fetch-pipeline definitions: address width, NOP encoding, imem FSM states.
package pipeline;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } imem_state_e;

  // Zero every byte lane whose select bit is clear.
  function automatic logic [31:0] sel_mask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_lat_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_cnt <= '0;
    else if (i_load)                    r_cnt <= i_val;
    else if (i_dec && (r_cnt != '0))    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction-bus responder: serves fetch reads from a synchronous SRAM with
// configurable wait states and read latency, flags bad addresses, and drops
// the response for requests the fetch unit abandons.
module instr_mem_ctrl #(
  parameter int               XLEN        = pipeline::XLEN,
  parameter logic [XLEN-1:0]  BASE_ADDR   = '0,
  parameter int               DEPTH_WORDS = 1024,
  parameter int               WAIT_STATES = 0,
  parameter int               MEM_LAT     = 1,
  localparam int              AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            re,
  input  logic [3:0]      sel,
  input  logic [XLEN-1:0] addr,
  output logic            ack,
  output logic [31:0]     instr,
  output logic            err,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [31:0]     mem_rdata
);
  import pipeline::*;

  localparam logic [XLEN-1:0] SPAN  = XLEN'(4 * DEPTH_WORDS);
  localparam logic [3:0]      WS_LD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [3:0]      ML_LD = 4'(MEM_LAT - 1);

  imem_state_e     r_state;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_sel;
  logic            r_live;   // cleared once re drops mid-transaction
  logic            r_err;
  logic [31:0]     r_data;   // response word for the current transaction
  logic [31:0]     r_hold;   // last word actually delivered

  logic [XLEN-1:0] w_off;
  logic            w_bad, w_ack, w_wait_zero, w_lat_zero;

  // Range check runs on the full-width offset, before truncation to AW.
  assign w_off = r_addr - BASE_ADDR;
  assign w_bad = (r_addr[1:0] != 2'b00) || (r_addr < BASE_ADDR) || (w_off >= SPAN);

  lat_counter #(.W(4)) u_wait_cnt (
    .clk(clk), .reset_n(reset_n),
    .i_load((r_state == S_IDLE) && re), .i_val(WS_LD),
    .i_dec(r_state == S_WAIT), .o_zero(w_wait_zero)
  );

  lat_counter #(.W(4)) u_lat_cnt (
    .clk(clk), .reset_n(reset_n),
    .i_load((r_state == S_ISSUE) && !w_bad), .i_val(ML_LD),
    .i_dec(r_state == S_READ), .o_zero(w_lat_zero)
  );

  // Transaction sequencing; the abandon flag tracks re through WAIT..READ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_sel   <= '0;
      r_live  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= NOP_INSTR;
    end else begin
      case (r_state)
        S_IDLE: if (re) begin
          r_addr  <= addr;
          r_sel   <= sel;
          r_live  <= 1'b1;
          r_state <= (WAIT_STATES > 0) ? S_WAIT : S_ISSUE;
        end
        S_WAIT: begin
          r_live <= r_live & re;
          if (w_wait_zero) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_live <= r_live & re;
          r_err  <= w_bad;
          if (w_bad) begin
            r_data  <= NOP_INSTR;
            r_state <= S_RESP;
          end else begin
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_live <= r_live & re;
          if (w_lat_zero) begin
            r_data  <= sel_mask(mem_rdata, r_sel);
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Remember the delivered word so instr only changes alongside ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_hold <= NOP_INSTR;
    else if (w_ack) r_hold <= r_data;
  end

  assign w_ack    = (r_state == S_RESP) && r_live && re;
  assign ack      = w_ack;
  assign err      = w_ack && r_err;
  assign instr    = w_ack ? r_data : r_hold;
  assign mem_en   = (r_state == S_ISSUE) && !w_bad;
  assign mem_addr = mem_en ? w_off[AW+1:2] : '0;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: channel 0 uses default timing, channel 1 uses
// WAIT_STATES=2 / MEM_LAT=3. A request-level model predicts every cycle.
module tb_instr_mem_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       re_v, ack_v, err_v, men_v;
  logic [1:0][3:0]  sel_v;
  logic [1:0][31:0] addr_v, instr_v, rdata_v;
  logic [1:0][9:0]  maddr_v;
  logic [31:0]      mem [0:1023];

  int checks   = 0;
  int failures = 0;
  int men0 = 0, men1 = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [3:0] s);
    logic [31:0] w;
    logic [31:0] r;
    w = mem[a[11:2]];
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? w[8*b +: 8] : 8'h00;
    return r;
  endfunction

  always @(posedge clk) begin
    if (men_v[0]) men0 <= men0 + 1;
    if (men_v[1]) men1 <= men1 + 1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int WS = (g == 0) ? 0 : 2;
    localparam int ML = (g == 0) ? 1 : 3;

    instr_mem_ctrl #(.WAIT_STATES(WS), .MEM_LAT(ML)) u_dut (
      .clk(clk), .reset_n(rst_n), .re(re_v[g]), .sel(sel_v[g]), .addr(addr_v[g]),
      .ack(ack_v[g]), .instr(instr_v[g]), .err(err_v[g]), .mem_en(men_v[g]),
      .mem_addr(maddr_v[g]), .mem_rdata(rdata_v[g])
    );

    // SRAM: data for a sampled mem_en appears ML cycles later.
    logic [31:0] sp [0:3];
    always @(posedge clk) begin
      sp[0] <= men_v[g] ? mem[maddr_v[g]] : 32'hBAD0_BAD0;
      for (int k = 1; k < 4; k++) sp[k] <= sp[k-1];
    end
    assign rdata_v[g] = sp[ML-1];

    // Request model: count cycles since acceptance, respond at a fixed latency.
    logic        m_busy, m_live, m_bad, e_ack, e_men;
    int          m_c, m_lat;
    logic [31:0] m_a, m_last, e_instr;
    logic [3:0]  m_s;

    assign m_bad   = bad_addr(m_a);
    assign m_lat   = m_bad ? (2 + WS) : (2 + WS + ML);
    assign e_ack   = m_busy && (m_c == m_lat) && m_live && re_v[g];
    assign e_men   = m_busy && (m_c == 1 + WS) && !m_bad;
    assign e_instr = m_bad ? NOP : ref_word(m_a, m_s);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy <= 1'b0; m_live <= 1'b0; m_c <= 0; m_a <= '0; m_s <= '0; m_last <= NOP;
      end else if (!m_busy) begin
        if (re_v[g]) begin
          m_busy <= 1'b1; m_c <= 1; m_a <= addr_v[g]; m_s <= sel_v[g]; m_live <= 1'b1;
        end
      end else if (m_c == m_lat) begin
        m_busy <= 1'b0;
        if (e_ack) m_last <= e_instr;
      end else begin
        m_c    <= m_c + 1;
        m_live <= m_live & re_v[g];
      end
    end

    always @(negedge clk) begin
      chk($sformatf("ch%0d_ack", g),    32'(ack_v[g]), 32'(e_ack));
      chk($sformatf("ch%0d_err", g),    32'(err_v[g]), 32'(e_ack && m_bad));
      chk($sformatf("ch%0d_mem_en", g), 32'(men_v[g]), 32'(e_men));
      chk($sformatf("ch%0d_instr", g),  instr_v[g],    e_ack ? e_instr : m_last);
      if (e_men)  chk($sformatf("ch%0d_mem_addr", g), 32'(maddr_v[g]), 32'(m_a[11:2]));
      if (!rst_n) chk($sformatf("ch%0d_rst_mem_addr", g), 32'(maddr_v[g]), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in an IDLE cycle and wait (bounded) for its ack.
  task automatic do_req(input int i, input logic [31:0] a, input logic [3:0] s, input bit keep,
                        output logic [31:0] oi, output logic oe, output int lat);
    addr_v[i] = a; sel_v[i] = s; re_v[i] = 1'b1;
    lat = -1; oi = '0; oe = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ack_v[i]) begin
        lat = n; oi = instr_v[i]; oe = err_v[i];
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL ch%0d_timeout addr=%0h got=no_ack want=ack_within_30", i, a);
    end
    if (!keep) begin
      re_v[i] = 1'b0;
      tick();
    end
  endtask

  logic [31:0] gi;
  logic        ge;
  int          gl, m0, m1;

  initial begin
    rst_n = 1'b0; re_v = '0; sel_v = '0; addr_v = '0;
    for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    mem[0] = 32'h0000_0093;
    mem[2] = 32'h1234_5678;
    mem[5] = 32'hDEAD_BEEF;
    mem[8] = 32'hAABB_CCDD;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack",    32'(ack_v[0]), 32'h0);
    chk("reset_err",    32'(err_v[0]), 32'h0);
    chk("reset_mem_en", 32'(men_v[0]), 32'h0);
    chk("reset_instr",  instr_v[0],    NOP);
    chk("reset_addr",   32'(maddr_v[0]), 32'h0);
    rst_n = 1'b1;
    tick();

    // Default timing read of word 5.
    m0 = men0;
    do_req(0, 32'h14, 4'hF, 1'b0, gi, ge, gl);
    chk("t1_instr", gi, 32'hDEAD_BEEF);
    chk("t1_err",   32'(ge), 32'h0);
    chk("t1_lat",   32'(gl), 32'd3);
    chk("t1_men",   32'(men0 - m0), 32'd1);

    // Back-to-back with a fresh address.
    do_req(0, 32'h14, 4'hF, 1'b1, gi, ge, gl);
    chk("b2b_lat1", 32'(gl), 32'd3);
    tick();
    do_req(0, 32'h20, 4'hF, 1'b0, gi, ge, gl);
    chk("b2b_instr", gi, 32'hAABB_CCDD);
    chk("b2b_lat2",  32'(gl), 32'd3);

    // Bad addresses: misaligned and just past the window.
    m0 = men0;
    do_req(0, 32'h6, 4'hF, 1'b0, gi, ge, gl);
    chk("t3a_instr", gi, NOP);
    chk("t3a_err",   32'(ge), 32'h1);
    chk("t3a_lat",   32'(gl), 32'd2);
    do_req(0, 32'h1000, 4'hF, 1'b0, gi, ge, gl);
    chk("t3b_instr", gi, NOP);
    chk("t3b_err",   32'(ge), 32'h1);
    chk("t3_no_men", 32'(men0 - m0), 32'd0);

    // Partial byte select.
    do_req(0, 32'h20, 4'b0011, 1'b0, gi, ge, gl);
    chk("t4_instr", gi, 32'h0000_CCDD);

    // Wait states and longer SRAM latency.
    m1 = men1;
    do_req(1, 32'h8, 4'hF, 1'b0, gi, ge, gl);
    chk("t2_instr", gi, 32'h1234_5678);
    chk("t2_lat",   32'(gl), 32'd7);
    chk("t2_men",   32'(men1 - m1), 32'd1);
    do_req(1, 32'h3, 4'hF, 1'b0, gi, ge, gl);
    chk("t2_bad_lat", 32'(gl), 32'd4);
    chk("t2_bad_err", 32'(ge), 32'h1);

    // Abandon in READ, re raised again during the dead RESP cycle.
    addr_v[0] = 32'h14; sel_v[0] = 4'hF; re_v[0] = 1'b1;
    tick();
    tick();
    re_v[0] = 1'b0;
    tick();
    addr_v[0] = 32'h0; re_v[0] = 1'b1;
    #1;
    chk("t5_no_ack", 32'(ack_v[0]), 32'h0);
    tick();
    do_req(0, 32'h0, 4'hF, 1'b0, gi, ge, gl);
    chk("t5_instr", gi, 32'h0000_0093);
    chk("t5_lat",   32'(gl), 32'd3);

    // Reset pulse mid-READ.
    addr_v[0] = 32'h14; sel_v[0] = 4'hF; re_v[0] = 1'b1;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    re_v[0] = 1'b0;
    #1;
    chk("t6_rst_men", 32'(men_v[0]), 32'h0);
    chk("t6_rst_ack", 32'(ack_v[0]), 32'h0);
    chk("t6_rst_err", 32'(err_v[0]), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    do_req(0, 32'h14, 4'hF, 1'b0, gi, ge, gl);
    chk("t6_instr", gi, 32'hDEAD_BEEF);
    chk("t6_lat",   32'(gl), 32'd3);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
